// File: rtl/pll_sequencer.sv
// rtl/pll_sequencer.sv - power-up and lock-recovery sequencer for the iCE40 PLL
//
// Runs on the 12 MHz reference clock, which is valid before the PLL locks.
// Ports:
//   clk_i         12 MHz reference clock
//   rst_i         asynchronous active-high reset
//   lock_i        PLL LOCK, asynchronous to clk_i
//   retry_i       one-cycle pulse, restarts sequencing from FAULT only
//   pll_resetb_o  PLL RESETB (active-low)
//   pll_bypass_o  PLL BYPASS
//   rst_no        downstream reset, active-low
//   ready_o       high while running on a locked PLL
//   fault_o       high in the terminal fault state
//   lock_lost_o   one-cycle pulse when lock loss is detected while running
//   retries_o     retries used in the current sequence
module pll_sequencer #(
    parameter int unsigned ResetCycles    = 12,
    parameter int unsigned LockTimeout    = 12000,
    parameter int unsigned StableCycles   = 1200,
    parameter int unsigned MaxRetries     = 3,
    parameter int unsigned LockLossFilter = 4,
    parameter bit          FaultBypass    = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       lock_i,
    input  logic       retry_i,
    output logic       pll_resetb_o,
    output logic       pll_bypass_o,
    output logic       rst_no,
    output logic       ready_o,
    output logic       fault_o,
    output logic       lock_lost_o,
    output logic [3:0] retries_o
);

    localparam int unsigned MaxCnt0 = (ResetCycles > LockTimeout) ? ResetCycles : LockTimeout;
    localparam int unsigned MaxCnt  = (MaxCnt0 > StableCycles) ? MaxCnt0 : StableCycles;
    localparam int unsigned CntW    = $clog2(MaxCnt + 1);
    localparam int unsigned FiltW   = $clog2(LockLossFilter + 1);

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [3:0]         retry_q, retry_d;
    logic [FiltW-1:0]   filt_q, filt_d;
    logic               lost_d;
    logic               timeout;
    logic               lock_meta, lock_s;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        filt_d  = filt_q;
        lost_d  = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            HOLD: begin
                if (cnt_q == CntW'(ResetCycles - 1)) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // lock is checked first so it wins over a coincident timeout
                if (lock_s)                               state_d = STABLE;
                else if (cnt_q == CntW'(LockTimeout - 1)) timeout = 1'b1;
            end
            STABLE: begin
                // a drop on the final cycle still counts as a failed attempt
                if (!lock_s)                               timeout = 1'b1;
                else if (cnt_q == CntW'(StableCycles - 1)) state_d = RUN;
            end
            RUN: begin
                if (lock_s) begin
                    filt_d = '0;
                end else if (filt_q == FiltW'(LockLossFilter - 1)) begin
                    filt_d  = '0;
                    lost_d  = 1'b1;
                    state_d = HOLD;
                end else begin
                    filt_d = filt_q + 1'b1;
                end
            end
            FAULT: begin
                if (retry_i) begin
                    retry_d = '0;
                    state_d = HOLD;
                end
            end
            default: state_d = HOLD;
        endcase

        if (timeout) begin
            if (retry_q == 4'(MaxRetries)) begin
                state_d = FAULT;
            end else begin
                retry_d = retry_q + 4'd1;
                state_d = HOLD;
            end
        end

        if (state_d == RUN && state_q != RUN) retry_d = '0;

        // counter only times HOLD/WAIT_LOCK/STABLE; parked at zero otherwise
        if (state_d != state_q || state_q == RUN || state_q == FAULT) cnt_d = '0;
        else                                                          cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_meta    <= 1'b0;
            lock_s       <= 1'b0;
            state_q      <= HOLD;
            cnt_q        <= '0;
            retry_q      <= '0;
            filt_q       <= '0;
            pll_resetb_o <= 1'b0;
            pll_bypass_o <= 1'b0;
            rst_no       <= 1'b0;
            ready_o      <= 1'b0;
            fault_o      <= 1'b0;
            lock_lost_o  <= 1'b0;
        end else begin
            lock_meta    <= lock_i;
            lock_s       <= lock_meta;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            filt_q       <= filt_d;
            // outputs decoded from next state so they move with the state register
            pll_resetb_o <= (state_d == WAIT_LOCK) || (state_d == STABLE);
            pll_bypass_o <= (state_d == FAULT) && FaultBypass;
            rst_no       <= (state_d == RUN) || ((state_d == FAULT) && FaultBypass);
            ready_o      <= (state_d == RUN);
            fault_o      <= (state_d == FAULT);
            lock_lost_o  <= lost_d;
        end
    end

    assign retries_o = retry_q;

endmodule

// File: tb/tb_pll_sequencer.sv
// tb/tb_pll_sequencer.sv - randomized scoreboard bench for pll_sequencer (both bypass variants)
module tb_pll_sequencer;

    localparam int RC  = 4;
    localparam int LT  = 16;
    localparam int SC  = 8;
    localparam int MR  = 2;
    localparam int LLF = 3;

    localparam int P_HOLD   = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_FAULT  = 4;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic lock_i = 1'b0;
    logic retry_i = 1'b0;

    logic       resetb0, bypass0, rstn0, ready0, fault0, lost0;
    logic [3:0] retries0;
    logic       resetb1, bypass1, rstn1, ready1, fault1, lost1;
    logic [3:0] retries1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    pll_sequencer #(.ResetCycles(RC), .LockTimeout(LT), .StableCycles(SC),
                    .MaxRetries(MR), .LockLossFilter(LLF), .FaultBypass(1'b0)) u_dut0 (
        .clk_i(clk), .rst_i(rst_i), .lock_i(lock_i), .retry_i(retry_i),
        .pll_resetb_o(resetb0), .pll_bypass_o(bypass0), .rst_no(rstn0),
        .ready_o(ready0), .fault_o(fault0), .lock_lost_o(lost0), .retries_o(retries0));

    pll_sequencer #(.ResetCycles(RC), .LockTimeout(LT), .StableCycles(SC),
                    .MaxRetries(MR), .LockLossFilter(LLF), .FaultBypass(1'b1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_i), .lock_i(lock_i), .retry_i(retry_i),
        .pll_resetb_o(resetb1), .pll_bypass_o(bypass1), .rst_no(rstn1),
        .ready_o(ready1), .fault_o(fault1), .lock_lost_o(lost1), .retries_o(retries1));

    function automatic logic [9:0] observed(int m);
        if (m == 0) return {resetb0, bypass0, rstn0, ready0, fault0, lost0, retries0};
        else        return {resetb1, bypass1, rstn1, ready1, fault1, lost1, retries1};
    endfunction

    // ---------------- reference model ----------------
    // Lock as seen by the sequencer is lock_i delayed by two reference edges.
    bit  lock_hist [2];
    int  phase [2];
    int  age   [2];
    int  lows  [2];
    int  tries [2];
    bit  lost_p[2];
    logic [19:0] exp_q [$];

    task automatic model_reset();
        lock_hist[0] = 1'b0;
        lock_hist[1] = 1'b0;
        for (int m = 0; m < 2; m++) begin
            phase[m] = P_HOLD; age[m] = 0; lows[m] = 0; tries[m] = 0; lost_p[m] = 1'b0;
        end
    endtask

    task automatic enter(int m, int p);
        phase[m] = p;
        age[m]   = 0;
    endtask

    task automatic attempt_failed(int m);
        if (tries[m] == MR) enter(m, P_FAULT);
        else begin
            tries[m] = tries[m] + 1;
            enter(m, P_HOLD);
        end
    endtask

    task automatic step(int m, bit lk, bit rt);
        lost_p[m] = 1'b0;
        case (phase[m])
            P_HOLD: begin
                age[m]++;
                if (age[m] == RC) enter(m, P_WAIT);
            end
            P_WAIT: begin
                age[m]++;
                if (lk) enter(m, P_STABLE);
                else if (age[m] == LT) attempt_failed(m);
            end
            P_STABLE: begin
                age[m]++;
                if (!lk) attempt_failed(m);
                else if (age[m] == SC) begin
                    enter(m, P_RUN);
                    tries[m] = 0;
                end
            end
            P_RUN: begin
                lows[m] = lk ? 0 : lows[m] + 1;
                if (lows[m] == LLF) begin
                    lows[m]   = 0;
                    lost_p[m] = 1'b1;
                    enter(m, P_HOLD);
                end
            end
            default: begin
                if (rt) begin
                    tries[m] = 0;
                    enter(m, P_HOLD);
                end
            end
        endcase
    endtask

    function automatic logic [9:0] expected(int m);
        bit fb;
        bit in_fault;
        fb = (m == 1);
        in_fault = (phase[m] == P_FAULT);
        return {(phase[m] == P_WAIT) || (phase[m] == P_STABLE),
                in_fault && fb,
                (phase[m] == P_RUN) || (in_fault && fb),
                phase[m] == P_RUN,
                in_fault,
                lost_p[m],
                4'(tries[m])};
    endfunction

    always @(posedge clk) begin
        bit lk;
        cyc++;
        if (rst_i) begin
            model_reset();
        end else begin
            lk = lock_hist[1];
            lock_hist[1] = lock_hist[0];
            lock_hist[0] = lock_i;
            for (int m = 0; m < 2; m++) step(m, lk, retry_i);
        end
        exp_q.push_back({expected(1), expected(0)});
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [19:0] e;
        logic [9:0]  want;
        logic [9:0]  got;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            for (int m = 0; m < 2; m++) begin
                want = (m == 0) ? e[9:0] : e[19:10];
                got  = observed(m);
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL outputs_fb%0d cyc=%0d got={resetb,bypass,rst_n,ready,fault,lost,retries}=%b required=%b",
                             m, cyc, got, want);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(bit level, int n, bit rand_retry);
        lock_i = level;
        for (int i = 0; i < n; i++) begin
            retry_i = rand_retry && ($urandom_range(0, 11) == 0);
            @(negedge clk);
        end
        retry_i = 1'b0;
    endtask

    task automatic pulse_retry();
        retry_i = 1'b1;
        @(negedge clk);
        retry_i = 1'b0;
    endtask

    // reset asserted between edges must reach the outputs without a clock edge
    task automatic async_reset(string tag);
        @(negedge clk);
        #2 rst_i = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            total++;
            if (observed(m) !== 10'b0) begin
                bad++;
                $display("FAIL async_reset_%s_fb%0d got=%b required=%b", tag, m, observed(m), 10'b0);
            end
        end
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    initial begin
        model_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;

        // lock up, glitches in RUN of 2 and 3 samples, retry ignored in RUN
        drive(1'b0, 10, 1'b0);
        drive(1'b1, 30, 1'b0);
        pulse_retry();
        drive(1'b0, 2, 1'b0);
        drive(1'b1, 10, 1'b0);
        drive(1'b0, 3, 1'b0);
        drive(1'b1, 9, 1'b0);
        drive(1'b0, 1, 1'b0);
        drive(1'b1, 40, 1'b0);
        async_reset("run");

        // no lock at all: three attempts then FAULT, retry back to HOLD
        drive(1'b0, 70, 1'b0);
        pulse_retry();
        drive(1'b0, 6, 1'b0);
        drive(1'b1, 30, 1'b0);
        async_reset("wait_lock");
        drive(1'b0, 6, 1'b0);
        async_reset("wait_lock2");

        // randomized lock waveform with random retry pulses
        for (int s = 0; s < 250; s++) begin
            int len;
            if ($urandom_range(0, 2) == 0) len = $urandom_range(1, 4);
            else                           len = $urandom_range(5, 70);
            drive(1'($urandom_range(0, 1)), len, 1'b1);
            if ($urandom_range(0, 60) == 0) async_reset("random");
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
